// File: rtl/demux1x8_frame.sv
// Frame demultiplexer: collects eight 4-bit beats of a time-multiplexed frame
// into a shadow buffer and publishes the whole frame on y0..y7 at once.
module demux1x8_frame (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       sof,
    output logic [3:0] y0,
    output logic [3:0] y1,
    output logic [3:0] y2,
    output logic [3:0] y3,
    output logic [3:0] y4,
    output logic [3:0] y5,
    output logic [3:0] y6,
    output logic [3:0] y7,
    output logic [2:0] slot,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          state_q, state_n;
    logic [2:0]      slot_q, slot_n;
    logic [7:0][3:0] shadow_q, shadow_n;
    logic [7:0][3:0] y_q, y_n;
    logic            frame_done_q, frame_done_n;
    logic            err_q, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= 3'd0;
            shadow_q     <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_n;
            slot_q       <= slot_n;
            shadow_q     <= shadow_n;
            y_q          <= y_n;
            frame_done_q <= frame_done_n;
            err_q        <= err_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        slot_n       = slot_q;
        shadow_n     = shadow_q;
        y_n          = y_q;
        frame_done_n = 1'b0;
        err_n        = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (sof) begin
                        shadow_n[0] = din;
                        slot_n      = 3'd1;
                        state_n     = RECV;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                RECV: begin
                    if (sof) begin
                        // Restart: the stale partial frame is simply overwritten.
                        err_n       = 1'b1;
                        shadow_n[0] = din;
                        slot_n      = 3'd1;
                    end else if (slot_q == 3'd7) begin
                        // Last beat bypasses the shadow so y sees all 8 slots together.
                        shadow_n[7]  = din;
                        y_n          = {din, shadow_q[6:0]};
                        frame_done_n = 1'b1;
                        slot_n       = 3'd0;
                        state_n      = IDLE;
                    end else begin
                        shadow_n[slot_q] = din;
                        slot_n           = slot_q + 3'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    slot_n  = 3'd0;
                end
            endcase
        end
    end

    assign y0         = y_q[0];
    assign y1         = y_q[1];
    assign y2         = y_q[2];
    assign y3         = y_q[3];
    assign y4         = y_q[4];
    assign y5         = y_q[5];
    assign y6         = y_q[6];
    assign y7         = y_q[7];
    assign slot       = slot_q;
    assign busy       = (state_q == RECV);
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule
